// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, mispredict flushes and interrupt
// injection/drain, producing Mealy handshakes for the ID->EX control-vector register.
module hazard_ctrl #(
    parameter int LU_STALL     = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int INT_DRAIN    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_x_rd,
    input  logic [4:0]  id_x_addr,
    input  logic        id_y_rd,
    input  logic [4:0]  id_y_addr,
    input  logic        ex_RF_WR,
    input  logic [1:0]  ex_RF_WR_SEL,
    input  logic [4:0]  ex_WB_ADDR,
    input  logic        ex_mispredict,
    input  logic        int_req,
    input  logic        i_en,
    output logic        nop,
    output logic        interupt,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        flush,
    output logic        int_ack,
    output logic [15:0] bubble_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [2:0] LU_LOAD    = 3'(LU_STALL - 1);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] DRAIN_LOAD = 3'(INT_DRAIN - 1);
    localparam logic [1:0] SEL_SCRATCH = 2'b01;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    logic x_hit, y_hit, lu, int_take;

    assign x_hit    = id_x_rd && (id_x_addr == ex_WB_ADDR);
    assign y_hit    = id_y_rd && (id_y_addr == ex_WB_ADDR);
    assign lu       = id_valid && ex_RF_WR && (ex_RF_WR_SEL == SEL_SCRATCH) && (x_hit || y_hit);
    assign int_take = int_req && i_en && id_valid;

    // cnt holds the bubbles still owed after the current cycle. The entry cycle of a
    // stall or flush is itself a bubble, so those states exit when one bubble is left;
    // the injection cycle is not a bubble, so DRAIN runs its full count.
    always_comb begin
        nop       = 1'b0;
        interupt  = 1'b0;
        pc_hold   = 1'b0;
        ifid_hold = 1'b0;
        flush     = 1'b0;
        int_ack   = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;

        if (rst) begin
            nop     = 1'b1;
            state_d = RUN;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_mispredict) begin
                        nop     = 1'b1;
                        flush   = 1'b1;
                        cnt_d   = FLUSH_LOAD;
                        state_d = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
                    end else if (int_take) begin
                        interupt = 1'b1;
                        int_ack  = 1'b1;
                        pc_hold  = 1'b1;
                        cnt_d    = DRAIN_LOAD;
                        state_d  = DRAIN;
                    end else if (lu) begin
                        nop       = 1'b1;
                        pc_hold   = 1'b1;
                        ifid_hold = 1'b1;
                        cnt_d     = LU_LOAD;
                        state_d   = (LU_STALL == 1) ? RUN : STALL;
                    end
                end

                STALL: begin
                    if (ex_mispredict) begin
                        // Squashed instructions make the pending stall irrelevant.
                        nop     = 1'b1;
                        flush   = 1'b1;
                        cnt_d   = FLUSH_LOAD;
                        state_d = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
                    end else begin
                        nop       = 1'b1;
                        pc_hold   = 1'b1;
                        ifid_hold = 1'b1;
                        if (cnt_q <= 3'd1) begin
                            cnt_d   = 3'd0;
                            state_d = RUN;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end

                FLUSH: begin
                    nop   = 1'b1;
                    flush = 1'b1;
                    if (ex_mispredict) begin
                        cnt_d   = FLUSH_LOAD;
                        state_d = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
                    end else if (cnt_q <= 3'd1) begin
                        cnt_d   = 3'd0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end

                DRAIN: begin
                    // EX carries the injected vector, so a mispredict flag here is stale.
                    nop   = 1'b1;
                    flush = 1'b1;
                    if (cnt_q == 3'd0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end

                default: begin
                    nop     = 1'b1;
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (nop && !rst && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            cnt_q        <= 3'd0;
            bubble_cnt_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one task per scenario, outputs checked mid-cycle.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_x_rd, id_y_rd;
    logic [4:0]  id_x_addr, id_y_addr;
    logic        ex_RF_WR;
    logic [1:0]  ex_RF_WR_SEL;
    logic [4:0]  ex_WB_ADDR;
    logic        ex_mispredict, int_req, i_en;
    logic        nop, interupt, pc_hold, ifid_hold, flush, int_ack;
    logic [15:0] bubble_cnt;
    logic [5:0]  outs;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_RST   = 6'b100000;
    localparam logic [5:0] O_STALL = 6'b101100;
    localparam logic [5:0] O_FLUSH = 6'b100010;
    localparam logic [5:0] O_INJ   = 6'b011001;

    hazard_ctrl #(.LU_STALL(1), .FLUSH_CYCLES(2), .INT_DRAIN(2)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_x_rd(id_x_rd), .id_x_addr(id_x_addr),
        .id_y_rd(id_y_rd), .id_y_addr(id_y_addr),
        .ex_RF_WR(ex_RF_WR), .ex_RF_WR_SEL(ex_RF_WR_SEL), .ex_WB_ADDR(ex_WB_ADDR),
        .ex_mispredict(ex_mispredict), .int_req(int_req), .i_en(i_en),
        .nop(nop), .interupt(interupt), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
        .flush(flush), .int_ack(int_ack), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    assign outs = {nop, interupt, pc_hold, ifid_hold, flush, int_ack};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_x_rd = 0; id_x_addr = 0; id_y_rd = 0; id_y_addr = 0;
        ex_RF_WR = 0; ex_RF_WR_SEL = 0; ex_WB_ADDR = 0;
        ex_mispredict = 0; int_req = 0; i_en = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic set_lu(input logic [4:0] addr);
        id_valid = 1; id_x_rd = 1; id_x_addr = addr;
        ex_RF_WR = 1; ex_RF_WR_SEL = 2'b01; ex_WB_ADDR = addr;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        set_lu(5'd5);
        for (int i = 0; i < 3; i++) begin
            mid();
            checks++;
            if (outs !== O_RST) begin
                errors++;
                $display("FAIL reset_outs cyc=%0d got=%b exp=%b", i, outs, O_RST);
            end
            tick();
        end
        rst = 0;
        mid();
        checks++;
        if (bubble_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_bubble got=%0d exp=0", bubble_cnt);
        end
        checks++;
        if (outs !== O_STALL) begin
            errors++;
            $display("FAIL reset_first_run got=%b exp=%b", outs, O_STALL);
        end
        tick();
        ex_RF_WR = 0;
        mid();
        checks++;
        if (outs !== O_IDLE || bubble_cnt !== 16'd1) begin
            errors++;
            $display("FAIL reset_after_stall outs=%b bubble=%0d exp=%b/1", outs, bubble_cnt, O_IDLE);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_lu(5'd5);
        mid();
        checks++;
        if (outs !== O_STALL) begin
            errors++;
            $display("FAIL lu_x_stall got=%b exp=%b", outs, O_STALL);
        end
        tick();
        ex_RF_WR = 0;
        mid();
        checks++;
        if (outs !== O_IDLE || bubble_cnt !== 16'd1) begin
            errors++;
            $display("FAIL lu_release outs=%b bubble=%0d exp=%b/1", outs, bubble_cnt, O_IDLE);
        end
        // Matching address but ALU write-back: no hazard.
        ex_RF_WR = 1; ex_RF_WR_SEL = 2'b00;
        mid();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL lu_sel00 got=%b exp=%b", outs, O_IDLE);
        end
        tick();
        // Y port hit.
        id_x_rd = 0; id_y_rd = 1; id_y_addr = 5'd7; ex_WB_ADDR = 5'd7; ex_RF_WR_SEL = 2'b01;
        mid();
        checks++;
        if (outs !== O_STALL) begin
            errors++;
            $display("FAIL lu_y_stall got=%b exp=%b", outs, O_STALL);
        end
        tick();
        // Same hazard pattern on an invalid ID slot.
        id_valid = 0;
        mid();
        checks++;
        if (outs !== O_IDLE || bubble_cnt !== 16'd2) begin
            errors++;
            $display("FAIL lu_invalid outs=%b bubble=%0d exp=%b/2", outs, bubble_cnt, O_IDLE);
        end
        tick();
    endtask

    task automatic test_mispredict();
        do_reset();
        ex_mispredict = 1;
        mid();
        checks++;
        if (outs !== O_FLUSH) begin
            errors++;
            $display("FAIL mp_c0 got=%b exp=%b", outs, O_FLUSH);
        end
        tick();
        ex_mispredict = 0;
        mid();
        checks++;
        if (outs !== O_FLUSH) begin
            errors++;
            $display("FAIL mp_c1 got=%b exp=%b", outs, O_FLUSH);
        end
        tick();
        mid();
        checks++;
        if (outs !== O_IDLE || bubble_cnt !== 16'd2) begin
            errors++;
            $display("FAIL mp_end outs=%b bubble=%0d exp=%b/2", outs, bubble_cnt, O_IDLE);
        end
        // Second pulse during the flush extends it by one bubble.
        do_reset();
        ex_mispredict = 1;
        tick();
        mid();
        checks++;
        if (outs !== O_FLUSH) begin
            errors++;
            $display("FAIL mp2_c1 got=%b exp=%b", outs, O_FLUSH);
        end
        tick();
        ex_mispredict = 0;
        mid();
        checks++;
        if (outs !== O_FLUSH) begin
            errors++;
            $display("FAIL mp2_c2 got=%b exp=%b", outs, O_FLUSH);
        end
        tick();
        mid();
        checks++;
        if (outs !== O_IDLE || bubble_cnt !== 16'd3) begin
            errors++;
            $display("FAIL mp2_end outs=%b bubble=%0d exp=%b/3", outs, bubble_cnt, O_IDLE);
        end
        tick();
    endtask

    task automatic test_interrupt();
        do_reset();
        int_req = 1; i_en = 1; id_valid = 1;
        mid();
        checks++;
        if (outs !== O_INJ) begin
            errors++;
            $display("FAIL int_inject got=%b exp=%b", outs, O_INJ);
        end
        tick();
        i_en = 0;
        ex_mispredict = 1;
        mid();
        checks++;
        if (outs !== O_FLUSH) begin
            errors++;
            $display("FAIL int_drain1 got=%b exp=%b", outs, O_FLUSH);
        end
        tick();
        ex_mispredict = 0;
        mid();
        checks++;
        if (outs !== O_FLUSH) begin
            errors++;
            $display("FAIL int_drain2 got=%b exp=%b", outs, O_FLUSH);
        end
        tick();
        mid();
        checks++;
        if (outs !== O_IDLE || bubble_cnt !== 16'd2) begin
            errors++;
            $display("FAIL int_no_reack outs=%b bubble=%0d exp=%b/2", outs, bubble_cnt, O_IDLE);
        end
        tick();
    endtask

    task automatic test_priority();
        do_reset();
        set_lu(5'd3);
        ex_mispredict = 1; int_req = 1; i_en = 1;
        mid();
        checks++;
        if (outs !== O_FLUSH) begin
            errors++;
            $display("FAIL prio_c0 got=%b exp=%b", outs, O_FLUSH);
        end
        tick();
        ex_mispredict = 0; ex_RF_WR = 0;
        mid();
        checks++;
        if (outs !== O_FLUSH) begin
            errors++;
            $display("FAIL prio_pending got=%b exp=%b", outs, O_FLUSH);
        end
        tick();
        mid();
        checks++;
        if (outs !== O_INJ) begin
            errors++;
            $display("FAIL prio_inject got=%b exp=%b", outs, O_INJ);
        end
        tick();
        int_req = 0;
        mid();
        checks++;
        if (bubble_cnt !== 16'd2) begin
            errors++;
            $display("FAIL prio_bubble got=%0d exp=2", bubble_cnt);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        ex_mispredict = 1;
        for (int i = 0; i < 70000; i++) tick();
        mid();
        checks++;
        if (bubble_cnt !== 16'hFFFF || outs !== O_FLUSH) begin
            errors++;
            $display("FAIL sat_hold bubble=%h outs=%b exp=ffff/%b", bubble_cnt, outs, O_FLUSH);
        end
        ex_mispredict = 0;
        rst = 1;
        tick();
        mid();
        checks++;
        if (bubble_cnt !== 16'd0) begin
            errors++;
            $display("FAIL sat_clear got=%h exp=0000", bubble_cnt);
        end
        rst = 0;
        tick();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_load_use();
        test_mispredict();
        test_interrupt();
        test_priority();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
